// File: rtl/rv32_scoreboard_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rv32_types (package)
//  Purpose : Shared types and constants for the RV32 scoreboard hazard unit:
//            register-id type, bypass-select encoding, long-latency defaults.
//  Revision: 1.0  initial release
// ============================================================================
package rv32_types;

    // Architectural register identifier (x0..x31).
    typedef logic [4:0] rv_reg_id_t;

    // Default number of long-latency writes that may be outstanding.
    localparam int MAX_LL_DEFAULT = 4;

    // bypass_sel encoding: 0 = register file, k = forwarding stage k-1.
    localparam int BYPASS_REGFILE = 0;

    function automatic int bypass_code(input int stage);
        return stage + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : rv32_reg_scoreboard
//  Purpose : Pending-write scoreboard for long-latency results. Holds one busy
//            bit per architectural register and a count of outstanding writes.
//  Ports   : clk, rst          clock / synchronous active-high reset
//            set_en, set_rd    mark set_rd busy (x0 is never marked)
//            clr_en, clr_rd    writeback of clr_rd (ignored if not busy)
//            busy              pending-write vector, bit 0 always 0
//            ll_cnt            number of busy bits currently set
//  Revision: 1.0  initial release
// ============================================================================
module rv32_reg_scoreboard
    import rv32_types::*;
#(
    parameter  int MAX_LL = MAX_LL_DEFAULT,
    localparam int CNT_W  = $clog2(MAX_LL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  rv_reg_id_t       set_rd,
    input  logic             clr_en,
    input  rv_reg_id_t       clr_rd,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] ll_cnt
);

    logic [31:0] busy_q;
    logic        do_set;
    logic        do_clr;
    logic        cnt_inc;
    logic        cnt_dec;

    always_comb begin
        do_set  = set_en && (set_rd != '0);
        // A writeback to a register that is not pending is stale; drop it.
        do_clr  = clr_en && busy_q[clr_rd];
        // Count moves only when a bit actually changes state.
        cnt_inc = do_set && !busy_q[set_rd];
        // Same-register set/clear: set wins, so the bit never drops.
        cnt_dec = do_clr && !(do_set && (set_rd == clr_rd));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            ll_cnt <= '0;
        end else begin
            // Ordering gives set priority over clear on the same register.
            if (do_clr) busy_q[clr_rd] <= 1'b0;
            if (do_set) busy_q[set_rd] <= 1'b1;

            if (cnt_inc && !cnt_dec && (ll_cnt != CNT_W'(MAX_LL)))
                ll_cnt <= ll_cnt + 1'b1;
            else if (cnt_dec && !cnt_inc && (ll_cnt != '0))
                ll_cnt <= ll_cnt - 1'b1;
        end
    end

    assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/rv32_scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module  : rv32_scoreboard_hazard_unit
//  Purpose : Decode-stage hazard detection and operand bypass selection with a
//            long-latency write scoreboard.
//  Ports   : clk, rst                 clock / synchronous active-high reset
//            use_rs, rs_id            per-slot operand use flag and register
//            fwd_rd/fwd_wb/fwd_is_load per forwarding stage (0 = youngest)
//            issue_valid/ll/rd        instruction leaving decode
//            ll_wb_valid/ll_wb_rd     long-latency regfile writeback
//            stall                    hold decode, insert bubble
//            bypass_sel               per slot, 0 = regfile, k = stage k-1
//            sb_busy                  scoreboard pending-write vector
//            stall_cnt                saturating stall-cycle counter
//  Revision: 1.0  initial release
// ============================================================================
module rv32_scoreboard_hazard_unit
    import rv32_types::*;
#(
    parameter  int NUM_RS     = 3,
    parameter  int NUM_FWD    = 2,
    parameter  int LOAD_READY = 1,
    parameter  int MAX_LL     = MAX_LL_DEFAULT,
    localparam int SEL_W      = $clog2(NUM_FWD + 1),
    localparam int CNT_W      = $clog2(MAX_LL + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic       [NUM_RS-1:0]       use_rs,
    input  rv_reg_id_t [NUM_RS-1:0]       rs_id,
    input  rv_reg_id_t [NUM_FWD-1:0]      fwd_rd,
    input  logic       [NUM_FWD-1:0]      fwd_wb,
    input  logic       [NUM_FWD-1:0]      fwd_is_load,
    input  logic                          issue_valid,
    input  logic                          issue_ll,
    input  rv_reg_id_t                    issue_rd,
    input  logic                          ll_wb_valid,
    input  rv_reg_id_t                    ll_wb_rd,
    output logic                          stall,
    output logic [NUM_RS-1:0][SEL_W-1:0]  bypass_sel,
    output logic [31:0]                   sb_busy,
    output logic [15:0]                   stall_cnt
);

    logic [NUM_RS-1:0] slot_stall;
    logic [CNT_W-1:0]  ll_cnt;
    logic              ll_full;
    logic              sb_set;

    for (genvar s = 0; s < NUM_RS; s++) begin : g_slot
        logic             active;
        logic             hit_load;
        logic [SEL_W-1:0] sel;

        always_comb begin
            active   = use_rs[s] && (rs_id[s] != '0);
            sel      = SEL_W'(BYPASS_REGFILE);
            hit_load = 1'b0;
            // Walk oldest to youngest so the youngest match is the one kept.
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_wb[k] && (fwd_rd[k] == rs_id[s])) begin
                    sel      = SEL_W'(bypass_code(k));
                    hit_load = fwd_is_load[k] && (k < LOAD_READY);
                end
            end
            if (!active) begin
                sel      = SEL_W'(BYPASS_REGFILE);
                hit_load = 1'b0;
            end
        end

        assign bypass_sel[s] = sel;
        // A pending long-latency write blocks the operand even if a stage
        // happens to carry the same rd.
        assign slot_stall[s] = active && (hit_load || sb_busy[rs_id[s]]);
    end

    assign ll_full = (ll_cnt == CNT_W'(MAX_LL));
    assign stall   = (|slot_stall) || (issue_ll && ll_full);
    assign sb_set  = issue_valid && !stall && issue_ll;

    rv32_reg_scoreboard #(
        .MAX_LL (MAX_LL)
    ) u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_en (sb_set),
        .set_rd (issue_rd),
        .clr_en (ll_wb_valid),
        .clr_rd (ll_wb_rd),
        .busy   (sb_busy),
        .ll_cnt (ll_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule
`default_nettype wire
